reg_bank: RTL and testbench

// Parametrised general-purpose register bank for the 19-bit CPU; replaces discrete A-C register instances.
// NUM_REGS words; 1 write port, 2 registered read ports; optional write-to-read bypass.
// Per-register pending scoreboard lets decode hold issue until an in-flight result is written back.

---
 rtl/reg_bank.sv | 111 +++++++++++
 tb/tb_reg_bank.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// General-purpose register bank: one write port, two registered read ports,
// optional write-to-read forwarding and a per-register pending scoreboard.
module reg_bank #(
    parameter int WORD_SIZE = 19,
    parameter int NUM_REGS  = 4,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter bit BYPASS    = 1'b1,
    parameter bit ZERO_REG  = 1'b0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CLR,
    input  logic                 LOAD_REG,
    input  logic [ADDR_W-1:0]    WR_ADDR,
    input  logic [WORD_SIZE-1:0] IN_DATA,
    input  logic                 RSV_EN,
    input  logic [ADDR_W-1:0]    RSV_ADDR,
    input  logic [ADDR_W-1:0]    RD_ADDR_A,
    input  logic [ADDR_W-1:0]    RD_ADDR_B,
    output logic [WORD_SIZE-1:0] OUT_DATA_A,
    output logic [WORD_SIZE-1:0] OUT_DATA_B,
    output logic                 OUT_READY_A,
    output logic                 OUT_READY_B,
    output logic [NUM_REGS-1:0]  PENDING_VEC
);

    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]  pend_q;
    logic [NUM_REGS-1:0]  pend_d;
    logic [NUM_REGS-1:0]  wr_sel;
    logic [NUM_REGS-1:0]  rsv_sel;

    logic [ADDR_W-1:0]    rd_addr   [2];
    logic [WORD_SIZE-1:0] rd_data_d [2];
    logic [WORD_SIZE-1:0] rd_data_q [2];
    logic [1:0]           rd_rdy_d;
    logic [1:0]           rd_rdy_q;

    assign rd_addr[0] = RD_ADDR_A;
    assign rd_addr[1] = RD_ADDR_B;

    // Decoders only cover implemented registers, so out-of-range addresses select nothing.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel[i]  = LOAD_REG && (WR_ADDR == ADDR_W'(i)) && !(ZERO_REG && i == 0);
            rsv_sel[i] = RSV_EN && (RSV_ADDR == ADDR_W'(i)) && !(ZERO_REG && i == 0);
        end
    end

    // Reserve is applied after the write clear so a same-address reservation wins.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = wr_sel[i] ? IN_DATA : regs_q[i];
            pend_d[i] = (pend_q[i] & ~wr_sel[i]) | rsv_sel[i];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_d[p] = '0;
            rd_rdy_d[p]  = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if ((rd_addr[p] == ADDR_W'(i)) && !(ZERO_REG && i == 0)) begin
                    if (BYPASS && wr_sel[i]) begin
                        rd_data_d[p] = IN_DATA;
                        rd_rdy_d[p]  = 1'b1;
                    end else begin
                        rd_data_d[p] = regs_q[i];
                        rd_rdy_d[p]  = ~pend_q[i];
                    end
                end
            end
        end
    end

    // Storage, scoreboard and read-port registers all update on the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_rdy_q     <= 2'b00;
        end else if (CLR) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pend_q       <= '0;
            rd_data_q[0] <= '0;
            rd_data_q[1] <= '0;
            rd_rdy_q     <= 2'b11;
        end else begin
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_rdy_q  <= rd_rdy_d;
        end
    end

    assign OUT_DATA_A  = rd_data_q[0];
    assign OUT_DATA_B  = rd_data_q[1];
    assign OUT_READY_A = rd_rdy_q[0];
    assign OUT_READY_B = rd_rdy_q[1];
    assign PENDING_VEC = pend_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: a default instance (4 regs, bypass) and a
// 3-register, no-bypass, zero-register instance share one stimulus stream.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        ld  = 1'b0;
    logic [1:0]  wa  = '0;
    logic [18:0] wd  = '0;
    logic        rsv = 1'b0;
    logic [1:0]  ra  = '0;
    logic [1:0]  rda = '0;
    logic [1:0]  rdb = '0;

    logic [18:0] da0, db0, da1, db1;
    logic        ya0, yb0, ya1, yb1;
    logic [3:0]  pv0;
    logic [2:0]  pv1;

    always #5 clk = ~clk;

    reg_bank dut0 (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD_REG(ld), .WR_ADDR(wa), .IN_DATA(wd),
        .RSV_EN(rsv), .RSV_ADDR(ra), .RD_ADDR_A(rda), .RD_ADDR_B(rdb),
        .OUT_DATA_A(da0), .OUT_DATA_B(db0), .OUT_READY_A(ya0), .OUT_READY_B(yb0),
        .PENDING_VEC(pv0)
    );

    reg_bank #(.WORD_SIZE(19), .NUM_REGS(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut1 (
        .CLK(clk), .RST(rst), .CLR(clr), .LOAD_REG(ld), .WR_ADDR(wa), .IN_DATA(wd),
        .RSV_EN(rsv), .RSV_ADDR(ra), .RD_ADDR_A(rda), .RD_ADDR_B(rdb),
        .OUT_DATA_A(da1), .OUT_DATA_B(db1), .OUT_READY_A(ya1), .OUT_READY_B(yb1),
        .PENDING_VEC(pv1)
    );

    typedef struct packed {
        logic [18:0] a0, b0; logic ra0, rb0; logic [3:0] p0;
        logic [18:0] a1, b1; logic ra1, rb1; logic [2:0] p1;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: plain arrays per configuration.
    logic [18:0] mem  [2][4];
    logic        pend [2][4];

    function automatic int nregs(int k);  return (k == 0) ? 4 : 3; endfunction
    function automatic bit byp(int k);    return (k == 0);         endfunction
    function automatic bit zreg(int k);   return (k == 1);         endfunction

    function automatic bit usable(int k, logic [1:0] a);
        return (int'(a) < nregs(k)) && !(zreg(k) && a == 2'd0);
    endfunction

    function automatic void rd_exp(input int k, input logic r, input logic c, input logic l,
                                   input logic [1:0] w, input logic [18:0] d, input logic [1:0] a,
                                   output logic [18:0] dat, output logic rdy);
        if (r) begin
            dat = '0; rdy = 1'b0;
        end else if (c || !usable(k, a)) begin
            dat = '0; rdy = 1'b1;
        end else if (byp(k) && l && w == a) begin
            dat = d; rdy = 1'b1;
        end else begin
            dat = mem[k][a]; rdy = !pend[k][a];
        end
    endfunction

    task automatic step(input logic r, input logic c, input logic l, input logic [1:0] w,
                        input logic [18:0] d, input logic s, input logic [1:0] sa,
                        input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        @(negedge clk);
        rst = r; clr = c; ld = l; wa = w; wd = d; rsv = s; ra = sa; rda = a; rdb = b;
        rd_exp(0, r, c, l, w, d, a, e.a0, e.ra0);
        rd_exp(0, r, c, l, w, d, b, e.b0, e.rb0);
        rd_exp(1, r, c, l, w, d, a, e.a1, e.ra1);
        rd_exp(1, r, c, l, w, d, b, e.b1, e.rb1);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                for (int i = 0; i < 4; i++) begin
                    mem[k][i]  = '0;
                    pend[k][i] = 1'b0;
                end
            end else begin
                if (l && usable(k, w)) begin
                    mem[k][w]  = d;
                    pend[k][w] = 1'b0;
                end
                if (s && usable(k, sa)) pend[k][sa] = 1'b1;
            end
        end
        e.p0 = {pend[0][3], pend[0][2], pend[0][1], pend[0][0]};
        e.p1 = {pend[1][2], pend[1][1], pend[1][0]};
        q.push_back(e);
    endtask

    task automatic idle_read(input logic [1:0] a, input logic [1:0] b);
        step(1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 1'b0, 2'd0, a, b);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("cfg0 data_a",  32'(da0), 32'(e.a0));
                chk("cfg0 data_b",  32'(db0), 32'(e.b0));
                chk("cfg0 ready_a", 32'(ya0), 32'(e.ra0));
                chk("cfg0 ready_b", 32'(yb0), 32'(e.rb0));
                chk("cfg0 pending", 32'(pv0), 32'(e.p0));
                chk("cfg1 data_a",  32'(da1), 32'(e.a1));
                chk("cfg1 data_b",  32'(db1), 32'(e.b1));
                chk("cfg1 ready_a", 32'(ya1), 32'(e.ra1));
                chk("cfg1 ready_b", 32'(yb1), 32'(e.rb1));
                chk("cfg1 pending", 32'(pv1), 32'(e.p1));
            end
        end
    end

    initial begin
        bit drained;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                mem[k][i] = '0; pend[k][i] = 1'b0;
            end

        // Reset cycle, then read every address on both ports.
        step(1'b1, 1'b0, 1'b0, 2'd0, 19'd0, 1'b0, 2'd0, 2'd0, 2'd1);
        idle_read(2'd0, 2'd1);
        idle_read(2'd2, 2'd3);

        // Full-scale word into r2, read back next cycle.
        step(1'b0, 1'b0, 1'b1, 2'd2, 19'h7FFFF, 1'b0, 2'd0, 2'd0, 2'd0);
        idle_read(2'd2, 2'd2);

        // Same-cycle write and read of r1: forwarded on cfg0, old value on cfg1.
        step(1'b0, 1'b0, 1'b1, 2'd1, 19'h00111, 1'b0, 2'd0, 2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'd1, 19'h12345, 1'b0, 2'd0, 2'd0, 2'd1);
        idle_read(2'd1, 2'd1);

        // Reserve r3, observe not-ready, then write back and observe ready.
        step(1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 1'b1, 2'd3, 2'd3, 2'd2);
        idle_read(2'd3, 2'd3);
        step(1'b0, 1'b0, 1'b1, 2'd3, 19'h00AAA, 1'b0, 2'd0, 2'd3, 2'd0);
        idle_read(2'd3, 2'd3);

        // Write and reserve r1 together: data lands, pending stays set.
        step(1'b0, 1'b0, 1'b1, 2'd1, 19'h00055, 1'b1, 2'd1, 2'd0, 2'd0);
        idle_read(2'd1, 2'd2);
        step(1'b0, 1'b0, 1'b0, 2'd0, 19'd0, 1'b1, 2'd2, 2'd1, 2'd2);

        // Clear while pending, with a write and reserve that must be dropped.
        step(1'b0, 1'b1, 1'b1, 2'd2, 19'h3CCCC, 1'b1, 2'd2, 2'd1, 2'd2);
        idle_read(2'd1, 2'd2);

        // Zero register and out-of-range address on the 3-register instance.
        step(1'b0, 1'b0, 1'b1, 2'd1, 19'h0ABCD, 1'b0, 2'd0, 2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 19'h54321, 1'b0, 2'd0, 2'd0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 19'h00001, 1'b1, 2'd0, 2'd0, 2'd3);
        step(1'b0, 1'b0, 1'b1, 2'd3, 19'h00001, 1'b1, 2'd3, 2'd3, 2'd0);
        idle_read(2'd0, 2'd3);
        idle_read(2'd1, 2'd2);

        // Randomised traffic with occasional clear and reset.
        for (int n = 0; n < 3000; n++) begin
            logic r, c;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 59) == 0);
            step(r, c, 1'($urandom), 2'($urandom), 19'($urandom), 1'($urandom_range(0, 2) == 0),
                 2'($urandom), 2'($urandom), 2'($urandom));
        end
        idle_read(2'd0, 2'd1);
        idle_read(2'd2, 2'd3);

        drained = 1'b0;
        for (int t = 0; t < 20 && !drained; t++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) drained = 1'b1;
        end
        if (!drained) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
